// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encoding, default playfield geometry and
// ball direction encodings used by the physics core and the paddle controllers.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_BALL_SIZE   = 10;
    localparam int DEF_PADDLE_LEN  = 50;
    localparam int DEF_PADDLE_W    = 5;
    localparam int DEF_PADDLE_STEP = 5;
    localparam int DEF_P1_X        = 30;
    localparam int DEF_P2_X        = 600;
    localparam int DEF_SPEED_MAX   = 4;
    localparam int DEF_WIN_SCORE   = 9;
    localparam int DEF_SERVE_FRAMES = 60;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: steps up/down by PADDLE_STEP on enabled frames, clamped to the
// playfield; contradictory or idle buttons leave it in place.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int PADDLE_LEN  = DEF_PADDLE_LEN,
    parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] btn_i,
    output logic [9:0] y_o
);
    localparam int         YMAX   = SCREEN_H - PADDLE_LEN;
    localparam logic [9:0] Y_INIT = 10'(YMAX / 2);

    logic [9:0] y_q, y_d;

    always_comb begin
        y_d = y_q;
        if (en_i) begin
            case (btn_i)
                2'b10:   y_d = (int'(y_q) + PADDLE_STEP > YMAX) ? 10'(YMAX) : y_q + 10'(PADDLE_STEP);
                2'b01:   y_d = (int'(y_q) < PADDLE_STEP) ? 10'd0 : y_q - 10'(PADDLE_STEP);
                default: y_d = y_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) y_q <= Y_INIT;
        else       y_q <= y_d;
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_physics.sv
// Pong game core: serve/play/over FSM, ball motion with wall and paddle
// bounces, miss scoring. Everything advances once per frame_tick.
module pong_physics
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_LEN   = DEF_PADDLE_LEN,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
    parameter int P1_X         = DEF_P1_X,
    parameter int P2_X         = DEF_P2_X,
    parameter int SPEED_MAX    = DEF_SPEED_MAX,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [1:0] btn_p1,
    input  logic [1:0] btn_p2,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] state,
    output logic       hit,
    output logic       miss,
    output logic       game_over
);
    localparam int                CW      = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0]        BALL_X0 = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]        BALL_Y0 = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [10:0] Y_BOT  = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] X_RGT  = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] BS1    = 11'(BALL_SIZE - 1);
    localparam logic signed [10:0] PL1    = 11'(PADDLE_LEN - 1);
    localparam logic signed [10:0] P1_L   = 11'(P1_X);
    localparam logic signed [10:0] P1_R   = 11'(P1_X + PADDLE_W - 1);
    localparam logic signed [10:0] P2_L   = 11'(P2_X);
    localparam logic signed [10:0] P2_R   = 11'(P2_X + PADDLE_W - 1);
    localparam logic [9:0]        P1_SNAP = 10'(P1_X + PADDLE_W);
    localparam logic [9:0]        P2_SNAP = 10'(P2_X - BALL_SIZE);
    localparam logic [3:0]        SPD_MAX = 4'(SPEED_MAX);
    localparam logic [3:0]        WIN     = 4'(WIN_SCORE);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [9:0]    bx_q, by_q, p1_y, p2_y;
    logic [3:0]    spd_q, s1_q, s2_q;
    logic          dx_q, dy_q, hit_q, miss_q, pad_en;

    assign pad_en = frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY);

    paddle_ctrl #(.SCREEN_H(SCREEN_H), .PADDLE_LEN(PADDLE_LEN), .PADDLE_STEP(PADDLE_STEP)) u_pad1 (
        .clk(clk), .reset(reset), .en_i(pad_en), .btn_i(btn_p1), .y_o(p1_y)
    );
    paddle_ctrl #(.SCREEN_H(SCREEN_H), .PADDLE_LEN(PADDLE_LEN), .PADDLE_STEP(PADDLE_STEP)) u_pad2 (
        .clk(clk), .reset(reset), .en_i(pad_en), .btn_i(btn_p2), .y_o(p2_y)
    );

    logic signed [10:0] bx_s, by_s, p1_s, p2_s, spd_s, nx, ny_raw, ny;
    logic dy_d, hit_l, hit_r, miss_l, miss_r, do_hit, do_miss, serve_go, serve_dir;

    // Candidate next ball position; collisions are judged against the paddles
    // as they stood before this frame's paddle move.
    always_comb begin
        bx_s   = $signed({1'b0, bx_q});
        by_s   = $signed({1'b0, by_q});
        p1_s   = $signed({1'b0, p1_y});
        p2_s   = $signed({1'b0, p2_y});
        spd_s  = $signed({7'd0, spd_q});
        nx     = (dx_q == DIR_RIGHT) ? bx_s + spd_s : bx_s - spd_s;
        ny_raw = (dy_q == DIR_DOWN) ? by_s + 11'sd1 : by_s - 11'sd1;
        ny     = ny_raw;
        dy_d   = dy_q;
        if (ny_raw < 11'sd0) begin
            ny   = 11'sd0;
            dy_d = DIR_DOWN;
        end else if (ny_raw > Y_BOT) begin
            ny   = Y_BOT;
            dy_d = DIR_UP;
        end
        hit_l = (dx_q == DIR_LEFT) && (nx + BS1 >= P1_L) && (nx <= P1_R)
                && (ny + BS1 >= p1_s) && (ny <= p1_s + PL1);
        hit_r = (dx_q == DIR_RIGHT) && (nx + BS1 >= P2_L) && (nx <= P2_R)
                && (ny + BS1 >= p2_s) && (ny <= p2_s + PL1);
        miss_l    = (nx <= 11'sd0);
        miss_r    = (nx >= X_RGT);
        do_hit    = frame_tick && (state_q == ST_PLAY) && (hit_l || hit_r);
        do_miss   = frame_tick && (state_q == ST_PLAY) && !(hit_l || hit_r) && (miss_l || miss_r);
        serve_go  = ((state_q == ST_IDLE || state_q == ST_OVER) && start) || do_miss;
        serve_dir = (do_miss && miss_l) ? DIR_LEFT : DIR_RIGHT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bx_q    <= BALL_X0;
            by_q    <= BALL_Y0;
            spd_q   <= 4'd1;
            dx_q    <= DIR_RIGHT;
            dy_q    <= DIR_DOWN;
            s1_q    <= '0;
            s2_q    <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            hit_q  <= do_hit;
            miss_q <= do_miss;
            case (state_q)
                ST_IDLE, ST_OVER: if (start) begin
                    state_q <= ST_SERVE;
                    s1_q    <= '0;
                    s2_q    <= '0;
                end
                ST_SERVE: if (frame_tick) begin
                    if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        state_q <= ST_PLAY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PLAY: if (frame_tick) begin
                    by_q <= ny[9:0];
                    dy_q <= dy_d;
                    if (do_hit) begin
                        bx_q  <= hit_l ? P1_SNAP : P2_SNAP;
                        dx_q  <= hit_l ? DIR_RIGHT : DIR_LEFT;
                        spd_q <= (spd_q >= SPD_MAX) ? SPD_MAX : spd_q + 4'd1;
                    end else if (miss_l) begin
                        s2_q    <= (s2_q >= WIN) ? WIN : s2_q + 4'd1;
                        state_q <= (s2_q + 4'd1 >= WIN) ? ST_OVER : ST_SERVE;
                    end else if (miss_r) begin
                        s1_q    <= (s1_q >= WIN) ? WIN : s1_q + 4'd1;
                        state_q <= (s1_q + 4'd1 >= WIN) ? ST_OVER : ST_SERVE;
                    end else begin
                        bx_q <= nx[9:0];
                    end
                end
                default: ;
            endcase
            // Re-centre the ball whenever a rally (re)starts or ends.
            if (serve_go) begin
                bx_q  <= BALL_X0;
                by_q  <= BALL_Y0;
                spd_q <= 4'd1;
                dx_q  <= serve_dir;
                dy_q  <= DIR_DOWN;
                cnt_q <= '0;
            end
        end
    end

    assign paddle1_y = p1_y;
    assign paddle2_y = p2_y;
    assign ball_x    = bx_q;
    assign ball_y    = by_q;
    assign score1    = s1_q;
    assign score2    = s2_q;
    assign state     = state_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_physics.sv
// Bench for pong_physics: directed serve/paddle/reset/game-over scenarios plus
// randomized play compared every cycle against a frame-level game model.
module tb_pong_physics;
    localparam int W = 640, H = 480, B = 10, PL = 50, PW = 5, PS = 5;
    localparam int P1X = 30, P2X = 600, SMAX = 4, WIN = 9, SF = 60;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start;
    logic [1:0] btn_p1, btn_p2;
    logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
    logic [3:0] score1, score2;
    logic [1:0] state;
    logic       hit, miss, game_over;

    always #5 clk = ~clk;

    pong_physics dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .btn_p1(btn_p1), .btn_p2(btn_p2),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .ball_x(ball_x), .ball_y(ball_y),
        .score1(score1), .score2(score2), .state(state),
        .hit(hit), .miss(miss), .game_over(game_over)
    );

    int n_chk, n_pass;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Game model: state 0..3, ball/paddles in pixels, direction flags.
    int m_st, m_p1, m_p2, m_bx, m_by, m_vx, m_right, m_down, m_s1, m_s2, m_cnt, m_hit, m_miss;

    task automatic model_serve(input int toward_right);
        m_st = 1; m_bx = (W - B) / 2; m_by = (H - B) / 2;
        m_vx = 1; m_right = toward_right; m_down = 1; m_cnt = 0;
    endtask

    task automatic model_reset();
        model_serve(1);
        m_st = 0; m_p1 = (H - PL) / 2; m_p2 = (H - PL) / 2;
        m_s1 = 0; m_s2 = 0; m_hit = 0; m_miss = 0;
    endtask

    function automatic int moved(input int y, input logic [1:0] b);
        if (b == 2'b10) return (y + PS > H - PL) ? H - PL : y + PS;
        if (b == 2'b01) return (y - PS < 0) ? 0 : y - PS;
        return y;
    endfunction

    function automatic bit overlap(input int a0, input int a1, input int b0, input int b1);
        return (a1 >= b0) && (a0 <= b1);
    endfunction

    task automatic model_play(input int op1, input int op2);
        int nx, ny;
        nx = m_bx + (m_right ? m_vx : -m_vx);
        ny = m_by + (m_down ? 1 : -1);
        if (ny < 0) begin ny = 0; m_down = 1; end
        else if (ny + B - 1 > H - 1) begin ny = H - B; m_down = 0; end
        if (!m_right && overlap(nx, nx + B - 1, P1X, P1X + PW - 1) && overlap(ny, ny + B - 1, op1, op1 + PL - 1)) begin
            m_bx = P1X + PW; m_by = ny; m_right = 1; m_vx = (m_vx + 1 > SMAX) ? SMAX : m_vx + 1; m_hit = 1;
        end else if (m_right && overlap(nx, nx + B - 1, P2X, P2X + PW - 1) && overlap(ny, ny + B - 1, op2, op2 + PL - 1)) begin
            m_bx = P2X - B; m_by = ny; m_right = 0; m_vx = (m_vx + 1 > SMAX) ? SMAX : m_vx + 1; m_hit = 1;
        end else if (nx <= 0) begin
            m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; m_miss = 1;
            model_serve(0);
            if (m_s2 == WIN) m_st = 3;
        end else if (nx + B - 1 >= W - 1) begin
            m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; m_miss = 1;
            model_serve(1);
            if (m_s1 == WIN) m_st = 3;
        end else begin
            m_bx = nx; m_by = ny;
        end
    endtask

    task automatic model_step(input logic ft, input logic st, input logic [1:0] b1, input logic [1:0] b2);
        int op1, op2;
        m_hit = 0; m_miss = 0;
        if ((m_st == 0 || m_st == 3) && st) begin
            m_s1 = 0; m_s2 = 0;
            model_serve(1);
        end else if (ft) begin
            op1 = m_p1; op2 = m_p2;
            if (m_st == 1 || m_st == 2) begin m_p1 = moved(m_p1, b1); m_p2 = moved(m_p2, b2); end
            if (m_st == 1) begin
                if (m_cnt == SF - 1) begin m_st = 2; m_cnt = 0; end
                else m_cnt++;
            end else if (m_st == 2) begin
                model_play(op1, op2);
            end
        end
    endtask

    task automatic cmp_all();
        chk("state", state, m_st);
        chk("paddle1_y", paddle1_y, m_p1);
        chk("paddle2_y", paddle2_y, m_p2);
        chk("ball_x", ball_x, m_bx);
        chk("ball_y", ball_y, m_by);
        chk("score1", score1, m_s1);
        chk("score2", score2, m_s2);
        chk("hit", hit, m_hit);
        chk("miss", miss, m_miss);
        chk("game_over", game_over, (m_st == 3) ? 1 : 0);
    endtask

    task automatic step(input logic ft, input logic st, input logic [1:0] b1, input logic [1:0] b2);
        @(negedge clk);
        frame_tick = ft; start = st; btn_p1 = b1; btn_p2 = b2;
        @(posedge clk);
        model_step(ft, st, b1, b2);
        #1 cmp_all();
    endtask

    // Paddle policy that keeps the paddle centred on the ball.
    function automatic logic [1:0] track(input int py, input int by);
        int pc, bc;
        pc = py + PL / 2; bc = by + B / 2;
        if (pc < bc - 4) return 2'b10;
        if (pc > bc + 4) return 2'b01;
        return 2'b00;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        model_reset();
        #1 cmp_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int mode, cyc;
        logic [1:0] b1, b2;
        n_chk = 0; n_pass = 0;
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; btn_p1 = 2'b00; btn_p2 = 2'b00;
        model_reset();
        #1;
        cmp_all();
        chk("rst_p1", paddle1_y, 215);
        chk("rst_bx", ball_x, 315);
        chk("rst_by", ball_y, 235);
        @(negedge clk);
        reset = 1'b0;

        // Serve countdown and paddle clamping.
        step(1, 0, 2'b00, 2'b00);
        chk("idle_hold", state, 0);
        step(0, 1, 2'b00, 2'b00);
        chk("start_serve", state, 1);
        for (int i = 0; i < 43; i++) step(1, 0, 2'b01, 2'b00);
        chk("p1_top_43", paddle1_y, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 2'b01, 2'b00);
        chk("p1_top_clamp", paddle1_y, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 2'b11, 2'b00);
        chk("p1_both_btn", paddle1_y, 0);
        step(0, 0, 2'b10, 2'b00);
        chk("p1_no_tick", paddle1_y, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 2'b10, 2'b00);
        chk("p1_down", paddle1_y, 10);
        for (int i = 0; i < 2; i++) step(1, 0, 2'b00, 2'b00);
        chk("serve_f59", state, 1);
        step(1, 0, 2'b00, 2'b00);
        chk("play_f60", state, 2);
        chk("play_bx", ball_x, 315);
        chk("play_by", ball_y, 235);

        // Randomized play with mixed tracking/random paddles.
        mode = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 256 == 0) mode = $urandom_range(0, 3);
            b1 = mode[0] ? track(m_p1, m_by) : 2'($urandom_range(0, 3));
            b2 = mode[1] ? track(m_p2, m_by) : 2'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, b1, b2);
        end

        // Asynchronous reset in the middle of a rally.
        cyc = 0;
        while (m_st != 2 && cyc < 200) begin
            step(1, (m_st == 0 || m_st == 3), 2'b00, 2'b00);
            cyc++;
        end
        chk("reach_play", state, 2);
        step(1, 0, 2'b10, 2'b01);
        @(negedge clk);
        frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_p1", paddle1_y, 215);
        chk("arst_p2", paddle2_y, 215);
        chk("arst_bx", ball_x, 315);
        chk("arst_by", ball_y, 235);
        chk("arst_s1", score1, 0);
        chk("arst_s2", score2, 0);
        chk("arst_hit_miss", {hit, miss, game_over}, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Full game: P1 never misses, so P1 must reach the winning score.
        do_reset();
        step(0, 1, 2'b00, 2'b00);
        cyc = 0;
        while (m_st != 3 && cyc < 40000) begin
            step(1, 0, track(m_p1, m_by), 2'($urandom_range(0, 3)));
            cyc++;
        end
        chk("over_reached", m_st, 3);
        chk("over_state", state, 3);
        chk("over_score1", score1, WIN);
        chk("over_game_over", game_over, 1);
        step(1, 0, 2'b00, 2'b00);
        chk("over_hold", state, 3);
        step(0, 1, 2'b00, 2'b00);
        chk("restart_state", state, 1);
        chk("restart_s1", score1, 0);
        chk("restart_s2", score2, 0);
        chk("restart_go", game_over, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
